// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared definitions for the bit-serial arithmetic family
//                (FSM state encoding, default width, counter sizing).
//  Revision    : 1.0  initial release
// ============================================================================
package serial_arith_pkg;

    // Default operand width for serial arithmetic blocks
    localparam int c_DEFAULT_WIDTH = 8;

    // Sequencer states shared by the serial adder and subtractor
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width: one spare bit so the counter can never wrap in a run
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/serial_add_cell.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_cell
//  Description : Combinational 1-bit full adder built from gate primitives;
//                the single arithmetic cell reused for every bit position.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_add_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output wire  s,
    output wire  co
);

    wire w_p;    // propagate: x ^ y
    wire w_g;    // generate:  x & y
    wire w_pc;   // propagated carry: (x ^ y) & ci

    xor u_xor_p  (w_p,  x,   y);
    xor u_xor_s  (s,    w_p, ci);
    and u_and_g  (w_g,  x,   y);
    and u_and_pc (w_pc, w_p, ci);
    or  u_or_co  (co,   w_g, w_pc);

endmodule : serial_add_cell
`default_nettype wire

// File: rtl/serial_adder_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_nbit
//  Description : Bit-serial N-bit adder. Operands and carry-in are captured on
//                an accepted start, then one bit per clock is summed LSB first
//                through a single full-adder cell and a carry flip-flop.
//                Sum, carry-out and signed overflow are registered on
//                completion and flagged with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder_nbit
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                 c_CNT_W = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    wire                w_s;
    wire                w_co;
    logic [WIDTH-1:0]   w_res_next;

    // The one shared adder cell: current LSBs plus the running carry
    serial_add_cell u_cell (
        .x  (r_a_sh[0]),
        .y  (r_b_sh[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // Result shift register contents once the current sum bit enters at the MSB
    always_comb begin
        w_res_next = {w_s, r_res_sh[WIDTH-1:1]};
    end

    // Sequencer, datapath shift registers, carry FF and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    // DONE accepts a new start exactly like IDLE (back-to-back)
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_res_sh <= w_res_next;
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        // r_carry still holds the carry into the MSB cell here
                        sum     <= w_res_next;
                        cout    <= w_co;
                        ovf     <= r_carry ^ w_co;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_adder_nbit
`default_nettype wire

// File: tb/tb_serial_adder_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_nbit
//  Description : Scoreboard bench for the bit-serial adder (WIDTH = 8) with
//                directed vectors and hand-computed expected results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder_nbit;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_err = 0;

    serial_adder_nbit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q_exp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check("sum",  32'(sum),  32'(e.s));
                check("cout", 32'(cout), 32'(e.c));
                check("ovf",  32'(ovf),  32'(e.o));
            end
        end
    end

    // Drive one request for a single edge (DUT assumed idle) and record expectation
    task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input exp_t e);
        a = ai; b = bi; cin = ci; start = 1'b1;
        q_exp.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Count edges until done; optionally verify the previous sum is held meanwhile
    task automatic wait_done(output int n, input logic chk_hold, input logic [7:0] hold_val);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (chk_hold) check("sum_held", 32'(sum), 32'(hold_val));
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got no done after %0d cycles expected done", n);
        end else begin
            check("busy_in_done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);

        // 0x3C + 0x0F + 1 = 0x4C, latency 8 edges after the start edge
        issue(8'h3C, 8'h0F, 1'b1, '{s: 8'h4C, c: 1'b0, o: 1'b0});
        wait_done(n, 1'b1, 8'h00);
        check("latency", 32'(n), 32'd8);
        @(posedge clk); #1;
        check("done_pulse_width", 32'(done), 32'd0);

        // 0xFF + 0x01 = 0x100: sum wraps, carry out
        issue(8'hFF, 8'h01, 1'b0, '{s: 8'h00, c: 1'b1, o: 1'b0});
        wait_done(n, 1'b1, 8'h4C);
        @(posedge clk); #1;

        // 0x7F + 0x01 = 0x80: signed overflow, prior result 0x00 held during run
        issue(8'h7F, 8'h01, 1'b0, '{s: 8'h80, c: 1'b0, o: 1'b1});
        wait_done(n, 1'b1, 8'h00);
        check("hold_cout_updated", 32'(cout), 32'd0);
        @(posedge clk); #1;

        // Start during RUN (bit 3) is ignored
        issue(8'h10, 8'h20, 1'b0, '{s: 8'h30, c: 1'b0, o: 1'b0});
        repeat (3) @(posedge clk);
        #1;
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, 1'b1, 8'h80);
        check("latency_ignored_start", 32'(n), 32'd4);
        repeat (12) @(posedge clk);
        #1;
        check("no_extra_busy", 32'(busy), 32'd0);

        // Back-to-back: start held high, new operands each DONE cycle
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        q_exp.push_back('{s: 8'h46, c: 1'b0, o: 1'b0});
        @(posedge clk); #1;
        wait_done(n, 1'b0, 8'h00);
        check("b2b_latency0", 32'(n), 32'd8);
        a = 8'h80; b = 8'h80; cin = 1'b0;
        q_exp.push_back('{s: 8'h00, c: 1'b1, o: 1'b1});
        @(posedge clk); #1;
        check("b2b_busy1", 32'(busy), 32'd1);
        wait_done(n, 1'b0, 8'h00);
        check("b2b_latency1", 32'(n), 32'd8);
        a = 8'hC0; b = 8'h40; cin = 1'b1;
        q_exp.push_back('{s: 8'h01, c: 1'b1, o: 1'b0});
        @(posedge clk); #1;
        check("b2b_busy2", 32'(busy), 32'd1);
        wait_done(n, 1'b0, 8'h00);
        check("b2b_latency2", 32'(n), 32'd8);
        a = 8'h55; b = 8'h2A; cin = 1'b1;
        q_exp.push_back('{s: 8'h80, c: 1'b0, o: 1'b1});
        @(posedge clk); #1;
        check("b2b_busy3", 32'(busy), 32'd1);
        wait_done(n, 1'b0, 8'h00);
        check("b2b_latency3", 32'(n), 32'd8);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle", 32'(busy), 32'd0);

        // Reset asserted at RUN bit 4 aborts immediately
        a = 8'h99; b = 8'h66; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf",  32'(ovf),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_abort_busy", 32'(busy), 32'd0);
        check("post_abort_sum",  32'(sum),  32'd0);

        // Fresh start after reset release
        issue(8'h01, 8'h02, 1'b1, '{s: 8'h04, c: 1'b0, o: 1'b0});
        wait_done(n, 1'b1, 8'h00);
        check("post_abort_latency", 32'(n), 32'd8);
        repeat (3) @(posedge clk);
        #1;

        check("scoreboard_drained", 32'(q_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_adder_nbit
`default_nettype wire
